// File: rtl/mac_result_drain_if.sv
// Handshake bundle between the MAC result tile, the drain block and the word sink.
// The drain block uses the slave side; whoever feeds tiles and consumes words uses master.
interface mac_result_drain_if #(
    parameter int M         = 2,
    parameter int N         = 2,
    parameter int OUT_WIDTH = 8
);
    localparam int ROW_W = $clog2(M) + 1;
    localparam int COL_W = $clog2(N) + 1;

    logic signed [31:0]          d_i [M][N];
    logic                        valid_i;
    logic                        ready_o;
    logic        [4:0]           shift_i;
    logic signed [OUT_WIDTH-1:0] out_data_o;
    logic                        out_valid_o;
    logic                        out_ready_i;
    logic                        out_last_o;
    logic        [ROW_W-1:0]     out_row_o;
    logic        [COL_W-1:0]     out_col_o;

    modport slave (
        input  d_i, valid_i, shift_i, out_ready_i,
        output ready_o, out_data_o, out_valid_o, out_last_o, out_row_o, out_col_o
    );

    modport master (
        output d_i, valid_i, shift_i, out_ready_i,
        input  ready_o, out_data_o, out_valid_o, out_last_o, out_row_o, out_col_o
    );
endinterface

// File: rtl/mac_result_drain.sv
// Captures an M x N accumulator tile and drains it one word per handshake in row-major
// order, requantizing each word with a rounding right shift and signed saturation.
module mac_result_drain #(
    parameter int M         = 2,
    parameter int N         = 2,
    parameter int OUT_WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    mac_result_drain_if.slave bus
);
    localparam int ROW_W = $clog2(M) + 1;
    localparam int COL_W = $clog2(N) + 1;
    localparam logic signed [32:0] SAT_MAX = (33'sd1 <<< (OUT_WIDTH - 1)) - 33'sd1;
    localparam logic signed [32:0] SAT_MIN = -(33'sd1 <<< (OUT_WIDTH - 1));

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t             state;
    logic signed [31:0] tile_p0 [M][N];
    logic        [4:0]  shift_p0;
    logic               vld_p0;
    logic               last_p0;
    logic [ROW_W-1:0]   row_p0;
    logic [COL_W-1:0]   col_p0;

    logic               ready;
    logic               accept;
    logic               out_hs;
    logic [ROW_W-1:0]   next_row;
    logic [COL_W-1:0]   next_col;
    logic signed [31:0] word;

    // 33 bits leave headroom for the rounding bias on the most positive input.
    function automatic logic signed [32:0] round_shift(input logic signed [31:0] x,
                                                       input logic [4:0] s);
        logic signed [32:0] ext;
        logic signed [32:0] bias;
        ext = {x[31], x};
        if (s == 5'd0) return ext;
        bias = 33'sd1 <<< (s - 5'd1);
        return (ext + bias) >>> s;
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [32:0] v);
        if (v > SAT_MAX) return SAT_MAX[OUT_WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
        return v[OUT_WIDTH-1:0];
    endfunction

    // A new tile may land on the same edge as the last word's handshake.
    assign out_hs = vld_p0 & bus.out_ready_i;
    assign ready  = (state == IDLE) | ((state == DRAIN) & out_hs & last_p0);
    assign accept = bus.valid_i & ready;

    always_comb begin
        next_row = row_p0;
        next_col = col_p0;
        if (col_p0 == COL_W'(N - 1)) begin
            next_col = '0;
            next_row = row_p0 + ROW_W'(1);
        end else begin
            next_col = col_p0 + COL_W'(1);
        end
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                if (row_p0 == ROW_W'(i) && col_p0 == COL_W'(j)) word = tile_p0[i][j];
            end
        end
    end

    // Capture stage: tile registers plus the drain FSM and its registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            vld_p0   <= 1'b0;
            last_p0  <= 1'b0;
            row_p0   <= '0;
            col_p0   <= '0;
            shift_p0 <= '0;
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) tile_p0[i][j] <= '0;
            end
        end else if (accept) begin
            state    <= DRAIN;
            vld_p0   <= 1'b1;
            last_p0  <= (M == 1) && (N == 1);
            row_p0   <= '0;
            col_p0   <= '0;
            shift_p0 <= bus.shift_i;
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) tile_p0[i][j] <= bus.d_i[i][j];
            end
        end else if (out_hs) begin
            if (last_p0) begin
                state   <= IDLE;
                vld_p0  <= 1'b0;
                last_p0 <= 1'b0;
                row_p0  <= '0;
                col_p0  <= '0;
            end else begin
                row_p0  <= next_row;
                col_p0  <= next_col;
                last_p0 <= (next_row == ROW_W'(M - 1)) && (next_col == COL_W'(N - 1));
            end
        end
    end

    // Output stage: requantize the selected word combinationally.
    assign bus.ready_o     = ready;
    assign bus.out_valid_o = vld_p0;
    assign bus.out_last_o  = last_p0;
    assign bus.out_row_o   = row_p0;
    assign bus.out_col_o   = col_p0;
    assign bus.out_data_o  = saturate(round_shift(word, shift_p0));
endmodule

// File: tb/tb_mac_result_drain.sv
// Scoreboard bench for mac_result_drain: accepted tiles push expected words, a negedge
// monitor compares every presented word against the queue head.
module tb_mac_result_drain;
    localparam int M  = 2;
    localparam int N  = 2;
    localparam int OW = 8;

    typedef struct {
        longint data;
        int     row;
        int     col;
        bit     last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mac_result_drain_if #(.M(M), .N(N), .OUT_WIDTH(OW)) bus();

    mac_result_drain #(.M(M), .N(N), .OUT_WIDTH(OW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   hs_cnt = 0;
    int   gap_cnt = 0;
    int   rdy_mode = 0;
    bit   rdy_force = 1'b1;
    int   cur_x [M][N];
    int   cur_s;

    // Reference: round half up by floor division, then clamp to the signed output range.
    function automatic longint model(longint x, int s);
        longint num, den, q, lo, hi;
        if (s == 0) begin
            q = x;
        end else begin
            num = x + (longint'(1) << (s - 1));
            den = longint'(1) << s;
            q = num / den;
            if ((num % den) != 0 && num < 0) q = q - 1;
        end
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -(longint'(1) << (OW - 1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send_tile(input bit keep);
        bit done;
        done = 1'b0;
        bus.valid_i = 1'b1;
        bus.shift_i = 5'(cur_s);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++) bus.d_i[r][c] = cur_x[r][c];
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.ready_o) begin
                done = 1'b1;
                for (int r = 0; r < M; r++)
                    for (int c = 0; c < N; c++)
                        sb.push_back('{model(longint'(cur_x[r][c]), cur_s), r, c,
                                       (r == M - 1) && (c == N - 1)});
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no acceptance expected one within 200 cycles");
        end
        @(posedge clk);
        #1;
        if (!keep) bus.valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid_o) done = 1'b1;
        end
        chk("drain_pending_words", longint'(sb.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_tile(input int a, input int b, input int c, input int d, input int s);
        cur_x[0][0] = a; cur_x[0][1] = b; cur_x[1][0] = c; cur_x[1][1] = d; cur_s = s;
    endtask

    task automatic rand_tile();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                case ($urandom_range(0, 2))
                    0:       cur_x[r][c] = int'($urandom);
                    1:       cur_x[r][c] = int'($urandom_range(0, 600)) - 300;
                    default: cur_x[r][c] = int'($urandom_range(0, 40)) - 20;
                endcase
        cur_s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
    endtask

    initial begin
        bus.out_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.out_ready_i = 1'b1;
                1:       bus.out_ready_i = ($urandom_range(0, 3) != 0);
                default: bus.out_ready_i = rdy_force;
            endcase
        end
    end

    // Monitor: every presented word must match the queue head; pop on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (bus.out_valid_o) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_word: got data=%0d row=%0d col=%0d expected no word",
                                 $signed(bus.out_data_o), bus.out_row_o, bus.out_col_o);
                    end else begin
                        e = sb[0];
                        if (longint'($signed(bus.out_data_o)) != e.data || int'(bus.out_row_o) != e.row ||
                            int'(bus.out_col_o) != e.col || bus.out_last_o != e.last) begin
                            failures++;
                            $display("FAIL word: got data=%0d row=%0d col=%0d last=%0d expected data=%0d row=%0d col=%0d last=%0d",
                                     $signed(bus.out_data_o), bus.out_row_o, bus.out_col_o, bus.out_last_o,
                                     e.data, e.row, e.col, e.last);
                        end
                        if (bus.out_ready_i) begin
                            void'(sb.pop_front());
                            hs_cnt++;
                        end
                    end
                end else begin
                    gap_cnt++;
                end
            end
        end
    end

    initial begin
        int hs0, gap0, vcount;
        bus.valid_i = 1'b0;
        bus.shift_i = '0;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++) bus.d_i[r][c] = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", longint'(bus.out_valid_o), 0);
        chk("reset_ready", longint'(bus.ready_o), 1);
        chk("reset_out_data", longint'($signed(bus.out_data_o)), 0);
        chk("reset_out_last", longint'(bus.out_last_o), 0);
        chk("reset_out_row", longint'(bus.out_row_o), 0);
        chk("reset_out_col", longint'(bus.out_col_o), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic tile with one-cycle latency and ready back high on the last word.
        set_tile(1, 2, 3, 4, 0);
        send_tile(1'b0);
        chk("latency_valid", longint'(bus.out_valid_o), 1);
        chk("first_word", longint'($signed(bus.out_data_o)), 1);
        chk("first_not_last", longint'(bus.out_last_o), 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("last_word", longint'($signed(bus.out_data_o)), 4);
        chk("last_flag", longint'(bus.out_last_o), 1);
        chk("ready_on_last", longint'(bus.ready_o), 1);
        wait_drain();

        // Saturation and rounding shift.
        set_tile(300, -300, 5, -6, 0);
        send_tile(1'b0);
        wait_drain();
        set_tile(6, -6, 7, 255, 2);
        send_tile(1'b0);
        wait_drain();

        // Backpressure for three cycles on word (0,1).
        rdy_mode = 2;
        rdy_force = 1'b1;
        rand_tile();
        send_tile(1'b0);
        @(posedge clk);
        #1;
        rdy_force = 1'b0;
        hs0 = hs_cnt;
        repeat (3) begin @(posedge clk); #1; end
        chk("stall_handshakes", longint'(hs_cnt - hs0), 0);
        chk("stall_col", longint'(bus.out_col_o), 1);
        rdy_force = 1'b1;
        wait_drain();
        rdy_mode = 0;

        // Back-to-back tiles with valid held high.
        hs0 = hs_cnt;
        rand_tile();
        send_tile(1'b1);
        gap0 = gap_cnt;
        rand_tile();
        send_tile(1'b0);
        repeat (4) @(negedge clk);
        chk("b2b_gaps", longint'(gap_cnt - gap0), 0);
        chk("b2b_words", longint'(hs_cnt - hs0), 8);
        wait_drain();

        // Inputs wiggle during drain while valid is low.
        rand_tile();
        send_tile(1'b0);
        repeat (4) begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < N; c++) bus.d_i[r][c] = int'($urandom);
            bus.shift_i = 5'($urandom_range(0, 31));
            @(posedge clk);
            #1;
        end
        wait_drain();

        // Reset after two of four words.
        rand_tile();
        send_tile(1'b0);
        repeat (2) begin @(posedge clk); #1; end
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", longint'(bus.out_valid_o), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("ready_after_reset", longint'(bus.ready_o), 1);
        vcount = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid_o) vcount++;
        end
        chk("no_residual_words", longint'(vcount), 0);
        @(posedge clk);
        #1;

        // Randomized tiles, gaps and backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            bit keep;
            keep = (i < 39) && ($urandom_range(0, 1) == 1);
            rand_tile();
            send_tile(keep);
            if (!keep) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_drain();
        rdy_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mac_result_drain.md
MAC_RESULT_DRAIN -- requirements
Module: mac_result_drain

Interface
REQ-001 SHALL have parameter M, default 2: rows of the result tile.
REQ-002 SHALL have parameter N, default 2: columns of the result tile.
REQ-003 SHALL have parameter OUT_WIDTH, default 8: signed output word width, range 2..32.
REQ-004 SHALL have clk_i  input  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have rst_ni  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have d_i  input  32 x [M][N]: signed accumulator tile, the result output of the sequential MAC.
REQ-007 SHALL have valid_i  input  1: the tile on d_i is valid.
REQ-008 SHALL have ready_o  output  1: the block accepts a tile; connects to the MAC's ready_out.
REQ-009 SHALL have shift_i  input  5: right-shift amount, sampled with the tile.
REQ-010 SHALL have out_data_o  output  OUT_WIDTH: requantized result word.
REQ-011 SHALL have out_valid_o  output  1: out_data_o is valid.
REQ-012 SHALL have out_ready_i  input  1: the downstream sink accepts the word.
REQ-013 SHALL have out_last_o  output  1: the current word is the final word of the tile.
REQ-014 SHALL have out_row_o  output  $clog2(M)+1: row index of the current word.
REQ-015 SHALL have out_col_o  output  $clog2(N)+1: column index of the current word.

Function
REQ-016 SHALL implement a two-state FSM with states IDLE and DRAIN.
REQ-017 SHALL treat a tile as accepted when valid_i and ready_o are both high at a rising edge; on acceptance it SHALL capture all M*N words of d_i and shift_i, clear row/col to 0, and enter DRAIN.
REQ-018 SHALL drive ready_o = (state==IDLE) | (state==DRAIN & out_valid_o & out_ready_i & out_last_o), combinationally.
REQ-019 SHALL, in DRAIN, hold out_valid_o high and emit words in row-major order: (0,0), (0,1), ..., (M-1,N-1).
REQ-020 SHALL advance to the next word only on a handshake (out_valid_o & out_ready_i); col SHALL wrap N-1 -> 0 with row incremented.
REQ-021 SHALL hold out_data_o, out_row_o, out_col_o and out_last_o stable while out_valid_o is high and out_ready_i is low.
REQ-022 SHALL assert out_last_o only on word (M-1,N-1).
REQ-023 SHALL, on the last-word handshake without a new acceptance, return to IDLE; if a new tile is accepted in the same cycle, SHALL stay in DRAIN at (0,0) with no gap cycle.
REQ-024 SHALL compute each output word combinationally from the captured word x and captured shift s:
  - s==0: y = x.
  - s>0: y = (sign-extend x to 33 bits + 2^(s-1)) arithmetic-shifted right by s (round half up).
REQ-025 SHALL saturate y to the signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-026 SHALL ignore d_i and shift_i when no acceptance occurs; captured data SHALL NOT change during DRAIN except on acceptance.
REQ-027 SHALL have a latency of 1 cycle from acceptance to out_valid_o high with word (0,0).
REQ-028 SHALL sustain throughput of one word per cycle while out_ready_i stays high, i.e. M*N cycles per tile back-to-back.

Reset
REQ-029 SHALL, on rst_ni low, immediately enter IDLE, with out_valid_o=0, out_last_o=0, out_row_o=0, out_col_o=0, out_data_o=0, captured tile=0 and captured shift=0; ready_o SHALL be 1 while in IDLE.
REQ-030 SHALL, when reset is asserted mid-DRAIN, discard the remaining words; after release the block SHALL be IDLE and SHALL emit nothing until a new acceptance.

Verification
REQ-031 SHALL cover: M=N=2, OUT_WIDTH=8, tile {1,2,3,4}, shift 0, out_ready_i=1 -> words 1,2,3,4 on cycles 1-4, out_last_o only on 4, ready_o high again in cycle 4.
REQ-032 SHALL cover: x=300, -300, 5, -6 with shift 0 -> 127, -128, 5, -6; then x=6, -6, 7, 255 with shift 2 -> 2, -1, 2, 64.
REQ-033 SHALL cover backpressure: out_ready_i low for 3 cycles on word (0,1) -> word, row/col and last held stable; order and count unchanged.
REQ-034 SHALL cover back-to-back tiles: valid_i held high with two tiles -> 8 consecutive valid words, no bubble, second tile captured exactly on the first tile's last handshake.
REQ-035 SHALL cover a changing input: d_i changes during DRAIN while valid_i is low -> output words unaffected.
REQ-036 SHALL cover reset after 2 of 4 words -> out_valid_o low asynchronously, ready_o=1 after release, no residual words.
